// File: rtl/parity_rx_if.sv
// Serial receive bundle: strobe and line in, received word, status flags and busy out.
interface parity_rx_if #(
  parameter int DATA_W = 8
);
  logic              bit_en;
  logic              serial_in;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;

  modport master (
    output bit_en, serial_in,
    input  data_out, data_valid, parity_err, frame_err, busy
  );

  modport slave (
    input  bit_en, serial_in,
    output data_out, data_valid, parity_err, frame_err, busy
  );
endinterface

// File: rtl/parity_rx.sv
// Serial frame receiver (start, DATA_W bits LSB first, parity, stop); results and data_valid
// are registered on the stop-bit sample edge. There is no backpressure, so each frame must be consumed on its data_valid pulse.
module parity_rx #(
  parameter int ODD_PARITY = 0,
  parameter int DATA_W     = 8
) (
  input  logic        clk,
  input  logic        reset,
  parity_rx_if.slave  bus
);

  localparam int   CW  = $clog2(DATA_W) + 1;
  localparam logic ODD = (ODD_PARITY != 0);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] shreg;
  logic              run_par;
  logic              rx_par;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              perr_q;
  logic              ferr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.bit_en) begin
      case (state)
        IDLE:    if (!bus.serial_in) state_nxt = DATA;
        DATA:    if (cnt == CW'(DATA_W - 1)) state_nxt = PARITY;
        PARITY:  state_nxt = STOP;
        STOP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.busy       = (state != IDLE);
    bus.data_out   = data_q;
    bus.data_valid = valid_q;
    bus.parity_err = perr_q;
    bus.frame_err  = ferr_q;
  end

  // data_valid defaults low every clock so it stays a single-cycle pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      shreg   <= '0;
      run_par <= 1'b0;
      rx_par  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (bus.bit_en) begin
        case (state)
          IDLE: begin
            if (!bus.serial_in) begin
              cnt     <= '0;
              run_par <= 1'b0;
            end
          end
          DATA: begin
            for (int i = 0; i < DATA_W; i++) begin
              if (cnt == CW'(i)) shreg[i] <= bus.serial_in;
            end
            run_par <= run_par ^ bus.serial_in;
            cnt     <= cnt + CW'(1);
          end
          PARITY: rx_par <= bus.serial_in;
          STOP: begin
            data_q  <= shreg;
            perr_q  <= rx_par ^ (run_par ^ ODD);
            ferr_q  <= ~bus.serial_in;
            valid_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_parity_rx.sv
// Directed vector bench for parity_rx; an even and an odd-parity instance see the same line.
module tb_parity_rx;

  logic clk = 1'b0;
  logic reset;
  logic bit_en;
  logic serial_in;

  always #5 clk = ~clk;

  parity_rx_if #(.DATA_W(8)) rx0 ();
  parity_rx_if #(.DATA_W(8)) rx1 ();

  assign rx0.bit_en    = bit_en;
  assign rx0.serial_in = serial_in;
  assign rx1.bit_en    = bit_en;
  assign rx1.serial_in = serial_in;

  parity_rx #(.ODD_PARITY(0), .DATA_W(8)) u_even (.clk(clk), .reset(reset), .bus(rx0.slave));
  parity_rx #(.ODD_PARITY(1), .DATA_W(8)) u_odd  (.clk(clk), .reset(reset), .bus(rx1.slave));

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       s;
    int         per;
    logic [7:0] xd;
    logic       xpe;
    logic       xfe;
    logic       xpo;
  } vec_t;

  vec_t tv [9];

  int nvec = 0;
  int errs = 0;
  int tick_n = 0;

  // Monitor: pulse count, pulses longer than one clock, busy clock count
  int   dv_n      = 0;
  int   dv_wide   = 0;
  int   busy_cyc  = 0;
  logic dv_prev   = 1'b0;

  always @(negedge clk) begin
    if (rx0.data_valid) dv_n++;
    if (rx0.data_valid && dv_prev) dv_wide++;
    dv_prev = rx0.data_valid;
    if (rx0.busy) busy_cyc++;
  end

  logic       got_vld;
  logic [7:0] got_d;
  logic       got_pe;
  logic       got_fe;
  logic       got_po;
  int         stamp;
  int         prev_stamp;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    tick_n++;
  endtask

  task automatic strobe(input logic b);
    serial_in = b;
    bit_en    = 1'b1;
    tick();
    bit_en    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int per);
    strobe(1'b0);
    idle(per - 1);
    for (int b = 0; b < 8; b++) begin
      strobe(d[b]);
      idle(per - 1);
    end
    strobe(p);
    idle(per - 1);
    strobe(s);
    got_vld = rx0.data_valid;
    got_d   = rx0.data_out;
    got_pe  = rx0.parity_err;
    got_fe  = rx0.frame_err;
    got_po  = rx1.parity_err;
    stamp   = tick_n;
    serial_in = 1'b1;
    idle(per - 1);
  endtask

  initial begin
    int b0;
    int n0;

    tv[0] = '{8'hFD, 1'b1, 1'b1, 1, 8'hFD, 1'b0, 1'b0, 1'b1};
    tv[1] = '{8'h0C, 1'b0, 1'b1, 1, 8'h0C, 1'b0, 1'b0, 1'b1};
    tv[2] = '{8'h64, 1'b1, 1'b1, 1, 8'h64, 1'b0, 1'b0, 1'b1};
    tv[3] = '{8'hFF, 1'b0, 1'b1, 1, 8'hFF, 1'b0, 1'b0, 1'b1};
    tv[4] = '{8'h64, 1'b0, 1'b1, 1, 8'h64, 1'b1, 1'b0, 1'b0};
    tv[5] = '{8'hFD, 1'b1, 1'b1, 1, 8'hFD, 1'b0, 1'b0, 1'b1};
    tv[6] = '{8'h0C, 1'b0, 1'b0, 1, 8'h0C, 1'b0, 1'b1, 1'b1};
    tv[7] = '{8'h0C, 1'b1, 1'b1, 1, 8'h0C, 1'b1, 1'b0, 1'b0};
    tv[8] = '{8'hFD, 1'b1, 1'b1, 4, 8'hFD, 1'b0, 1'b0, 1'b1};

    reset     = 1'b0;
    bit_en    = 1'b0;
    serial_in = 1'b1;
    prev_stamp = 0;
    #2 reset = 1'b1;
    #2;
    chk("rst_data_out",   rx0.data_out,   8'h00);
    chk("rst_data_valid", rx0.data_valid, 1'b0);
    chk("rst_parity_err", rx0.parity_err, 1'b0);
    chk("rst_frame_err",  rx0.frame_err,  1'b0);
    chk("rst_busy",       rx0.busy,       1'b0);
    idle(2);
    reset = 1'b0;
    idle(1);

    // Line idles high for 20 strobes
    b0 = busy_cyc;
    n0 = dv_n;
    for (int k = 0; k < 20; k++) strobe(1'b1);
    idle(1);
    chk("idle_busy_cycles", busy_cyc - b0, 0);
    chk("idle_no_valid",    dv_n - n0,     0);

    for (int i = 0; i < 9; i++) begin
      b0 = busy_cyc;
      send_frame(tv[i].d, tv[i].p, tv[i].s, tv[i].per);
      chk($sformatf("v%0d_valid", i),     got_vld, 1'b1);
      chk($sformatf("v%0d_data", i),      got_d,   tv[i].xd);
      chk($sformatf("v%0d_parity", i),    got_pe,  tv[i].xpe);
      chk($sformatf("v%0d_frame", i),     got_fe,  tv[i].xfe);
      chk($sformatf("v%0d_odd_parity", i), got_po, tv[i].xpo);
      if (i > 0 && tv[i].per == 1 && tv[i-1].per == 1)
        chk($sformatf("v%0d_spacing", i), stamp - prev_stamp, 11);
      if (tv[i].per == 4) begin
        chk("slow_valid_gone", rx0.data_valid, 1'b0);
        chk("slow_busy_cycles", busy_cyc - b0, 40);
      end
      prev_stamp = stamp;
    end

    // Reset after the 4th data bit of 0xFF abandons the frame
    n0 = dv_n;
    strobe(1'b0);
    for (int k = 0; k < 4; k++) strobe(1'b1);
    chk("mid_busy", rx0.busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("mid_rst_data_out",   rx0.data_out,   8'h00);
    chk("mid_rst_data_valid", rx0.data_valid, 1'b0);
    chk("mid_rst_parity_err", rx0.parity_err, 1'b0);
    chk("mid_rst_frame_err",  rx0.frame_err,  1'b0);
    chk("mid_rst_busy",       rx0.busy,       1'b0);
    idle(2);
    reset = 1'b0;
    idle(2);
    chk("mid_rst_no_valid", dv_n - n0, 0);

    send_frame(8'h0C, 1'b0, 1'b1, 1);
    chk("post_rst_valid",  got_vld, 1'b1);
    chk("post_rst_data",   got_d,   8'h0C);
    chk("post_rst_parity", got_pe,  1'b0);
    chk("post_rst_frame",  got_fe,  1'b0);
    idle(3);

    chk("valid_pulse_total", dv_n,    10);
    chk("valid_pulse_width", dv_wide, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule
